// File: rtl/vga_pingpong_fetch_pkg.sv
// vga_pkg: shared types and constants for the VGA ping-pong fetch unit.
// Bank/fetch state encodings, AXI codes and the colour-bar palette.
package vga_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_st_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } fetch_st_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] c;
    unique case (idx)
      3'd0:    c = COL_BLACK;
      3'd1:    c = COL_WHITE;
      3'd2:    c = COL_RED;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_BLUE;
      3'd5:    c = COL_YELLOW;
      3'd6:    c = COL_CYAN;
      default: c = COL_MAGENTA;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pingpong_fetch_if.sv
// vga_pingpong_fetch_if: AXI4 read-address and read-data bundle.
// master = fetch unit side, slave = memory/interconnect side.
interface vga_pingpong_fetch_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/vga_pingpong_fetch_bank.sv
// vga_pp_bank: one ping-pong bank, BURST_LEN words of DATA_WIDTH.
// Synchronous write, combinational read, own EMPTY/FILLING/FULL state.
module vga_pp_bank
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [$clog2(BURST_LEN)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [$clog2(BURST_LEN)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  input  logic                         st_we_i,
  input  bank_st_t                     st_i,
  output bank_st_t                     st_o
);
  logic [DATA_WIDTH-1:0] mem_q [BURST_LEN];
  bank_st_t st_q, st_d;

  // word storage, no reset: contents only matter once FULL
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // next bank state
  always_comb begin
    st_d = st_q;
    if (st_we_i) st_d = st_i;
  end

  // bank state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= EMPTY;
    else        st_q <= st_d;
  end

  assign rdata_o = mem_q[raddr_i];
  assign st_o    = st_q;
endmodule

// File: rtl/vga_pingpong_fetch.sv
// vga_pingpong_fetch: AXI4 burst frame fetch into two banks, pixel drain.
// Optional colour-bar self test when SELF_TEST_EN is defined.
module vga_pingpong_fetch
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int PIX_WIDTH  = 12,
  parameter int PIX_SLOT   = 16,
  parameter int BURST_LEN  = 32
) (
  input  logic                  clk_a,
  input  logic                  resetn_a,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  input  logic                  pix_req_i,
  input  logic                  self_test_i,
  output logic [PIX_WIDTH-1:0]  pix_o,
  output logic                  pix_valid_o,
  output logic                  underrun_o,
  output logic                  rerr_o,
  input  logic                  clr_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);
  localparam int SLOTS = DATA_WIDTH / PIX_SLOT;
  localparam int AW    = $clog2(BURST_LEN);
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] BURST_BYTES = AW1'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [AW-1:0]  LAST_BEAT   = AW'(BURST_LEN - 1);
  localparam logic [SW-1:0]  LAST_SLOT   = SW'(SLOTS - 1);
  localparam logic [7:0]     AR_LEN      = 8'(BURST_LEN - 1);
  localparam logic [2:0]     AR_SIZE     = 3'($clog2(DATA_WIDTH / 8));

  fetch_st_t state_q, state_d;

  logic                  cfg_q, cfg_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] top_q, top_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [AW-1:0]         beat_q, beat_d;
  logic                  fill_q, fill_d;
  logic                  drain_q, drain_d;
  logic [AW-1:0]         word_q, word_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [PIX_WIDTH-1:0]  pix_q, pix_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  rerr_q, rerr_d;

  logic [1:0]            bank_we;
  logic [1:0]            bank_st_we;
  bank_st_t              bank_st_set [2];
  bank_st_t              bank_st [2];
  logic [DATA_WIDTH-1:0] bank_rdata [2];
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rword;
  logic [PIX_WIDTH-1:0]  sel_pix;
  logic [AW1-1:0]        addr_sum;
  logic                  go;
  logic                  beat_fire;
  logic                  burst_end;
  logic                  early_last;
  logic                  drain_full;
  logic                  st_mode;

`ifdef SELF_TEST_EN
  logic [5:0] bar_cnt_q, bar_cnt_d;
  logic [2:0] bar_idx_q, bar_idx_d;
`else
  logic unused_self_test;
  assign unused_self_test = self_test_i;
`endif

  for (genvar i = 0; i < 2; i++) begin : g_bank
    vga_pp_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .BURST_LEN (BURST_LEN)
    ) u_bank (
      .clk    (clk_a),
      .rst_n  (resetn_a),
      .we_i   (bank_we[i]),
      .waddr_i(beat_q),
      .wdata_i(wdata),
      .raddr_i(word_q),
      .rdata_o(bank_rdata[i]),
      .st_we_i(bank_st_we[i]),
      .st_i   (bank_st_set[i]),
      .st_o   (bank_st[i])
    );
  end

  assign go = (state_q == IDLE) && enable_i && en_q &&
              (bank_st[fill_q] == EMPTY);
  assign beat_fire  = (state_q == DATA) && rvalid_i && rready_q;
  assign burst_end  = beat_fire && ((beat_q == LAST_BEAT) || rlast_i);
  assign early_last = beat_fire && rlast_i && (beat_q != LAST_BEAT);
  assign addr_sum   = {1'b0, next_q} + BURST_BYTES;
  assign wdata      = (rresp_i != RESP_OKAY) ? '0 : rdata_i;
  assign rword      = bank_rdata[drain_q];
  assign sel_pix    = PIX_WIDTH'(rword >> (slot_q * PIX_SLOT));
  assign drain_full = (bank_st[drain_q] == FULL);

`ifdef SELF_TEST_EN
  assign st_mode = self_test_i;
`else
  assign st_mode = 1'b0;
`endif

  // fetch FSM state register
  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // fetch FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = ADDR;
      ADDR:    if (arready_i) state_d = DATA;
      DATA:    if (burst_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // AXI outputs, address walk, bank fill/drain, pixel and status
  always_comb begin
    cfg_d       = 1'b1;
    en_d        = enable_i;
    base_d      = base_q;
    top_d       = top_q;
    next_d      = next_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    beat_d      = beat_q;
    fill_d      = fill_q;
    drain_d     = drain_q;
    word_d      = word_q;
    slot_d      = slot_q;
    pix_d       = pix_q;
    pix_valid_d = 1'b0;
    underrun_d  = underrun_q & ~clr_i;
    rerr_d      = rerr_q & ~clr_i;
    bank_we     = '0;
    bank_st_we  = '0;
    bank_st_set[0] = EMPTY;
    bank_st_set[1] = EMPTY;
`ifdef SELF_TEST_EN
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (go) begin
          araddr_d  = next_q;
          arvalid_d = 1'b1;
          beat_d    = '0;
          bank_st_we[fill_q]  = 1'b1;
          bank_st_set[fill_q] = FILLING;
        end
      end
      ADDR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          if (addr_sum >= {1'b0, top_q}) next_d = base_q;
          else                           next_d = addr_sum[ADDR_WIDTH-1:0];
        end
      end
      DATA: begin
        if (beat_fire) begin
          bank_we[fill_q] = 1'b1;
          beat_d = beat_q + 1'b1;
          if (rresp_i != RESP_OKAY) rerr_d = 1'b1;
        end
        if (burst_end) begin
          rready_d = 1'b0;
          fill_d   = ~fill_q;
          bank_st_we[fill_q]  = 1'b1;
          bank_st_set[fill_q] = FULL;
        end
        if (early_last) rerr_d = 1'b1;
      end
      default: ;
    endcase

    if (enable_i && !en_q) begin
      base_d = base_addr_i;
      top_d  = top_addr_i;
      next_d = base_addr_i;
    end

    if (pix_req_i) begin
      pix_valid_d = 1'b1;
      if (st_mode) begin
`ifdef SELF_TEST_EN
        pix_d     = PIX_WIDTH'(bar_color(bar_idx_q));
        bar_cnt_d = bar_cnt_q + 1'b1;
        if (bar_cnt_q == 6'd63) bar_idx_d = bar_idx_q + 1'b1;
`endif
      end else if (drain_full) begin
        pix_d = sel_pix;
        if (slot_q == LAST_SLOT) begin
          slot_d = '0;
          word_d = word_q + 1'b1;
          if (word_q == LAST_BEAT) begin
            drain_d = ~drain_q;
            bank_st_we[drain_q]  = 1'b1;
            bank_st_set[drain_q] = EMPTY;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end else begin
        pix_d      = '0;
        underrun_d = 1'b1;
      end
    end
  end

  // datapath and status registers
  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      cfg_q       <= 1'b0;
      en_q        <= 1'b0;
      base_q      <= '0;
      top_q       <= '0;
      next_q      <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      beat_q      <= '0;
      fill_q      <= 1'b0;
      drain_q     <= 1'b0;
      word_q      <= '0;
      slot_q      <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      en_q        <= en_d;
      base_q      <= base_d;
      top_q       <= top_d;
      next_q      <= next_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      beat_q      <= beat_d;
      fill_q      <= fill_d;
      drain_q     <= drain_d;
      word_q      <= word_d;
      slot_q      <= slot_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
      rerr_q      <= rerr_d;
    end
  end

`ifdef SELF_TEST_EN
  // colour-bar request counter and palette index
  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end
`endif

  assign pix_o       = pix_q;
  assign pix_valid_o = pix_valid_q;
  assign underrun_o  = underrun_q;
  assign rerr_o      = rerr_q;
  assign araddr_o    = araddr_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign arlen_o     = cfg_q ? AR_LEN : 8'd0;
  assign arsize_o    = cfg_q ? AR_SIZE : 3'd0;
  assign arburst_o   = cfg_q ? BURST_INCR : 2'b00;
endmodule

// File: tb/tb_vga_pingpong_fetch.sv
// tb_vga_pingpong_fetch: scoreboard bench for the ping-pong fetch unit.
// Directed bursts and pixel requests; monitors check AR and pixel output.
module tb_vga_pingpong_fetch;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] base = '0;
  logic [63:0] top = '0;
  logic        pix_req = 1'b0;
  logic        self_test = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] pix;
  logic        pix_valid;
  logic        underrun;
  logic        rerr;

  vga_pingpong_fetch_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) axi ();

  vga_pingpong_fetch dut (
    .clk_a      (clk),
    .resetn_a   (resetn),
    .enable_i   (enable),
    .base_addr_i(base),
    .top_addr_i (top),
    .pix_req_i  (pix_req),
    .self_test_i(self_test),
    .pix_o      (pix),
    .pix_valid_o(pix_valid),
    .underrun_o (underrun),
    .rerr_o     (rerr),
    .clr_i      (clr),
    .araddr_o   (axi.araddr),
    .arlen_o    (axi.arlen),
    .arsize_o   (axi.arsize),
    .arburst_o  (axi.arburst),
    .arvalid_o  (axi.arvalid),
    .arready_i  (axi.arready),
    .rdata_i    (axi.rdata),
    .rresp_i    (axi.rresp),
    .rlast_i    (axi.rlast),
    .rvalid_i   (axi.rvalid),
    .rready_o   (axi.rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pix;
    int          cyc;
  } pexp_t;

  pexp_t       pq[$];
  logic [63:0] aq[$];
  logic [63:0] exp_mem [2][32];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bw(input int p, input int k);
    if (p == 0 && k == 0) return 64'h0ABC_0DEF_0123_0456;
    return {16'(16'h0A00 + p * 16 + k), 16'(k * 3 + 1),
            16'(16'h0F00 - k), 16'(p * 256 + k * 5)};
  endfunction

  // pixel monitor: every valid pixel must match the oldest expectation
  always @(negedge clk) begin
    pexp_t e;
    if (resetn && pix_valid) begin
      if (pq.size() == 0) begin
        chk("pix_extra", pq.size(), 1);
      end else begin
        e = pq.pop_front();
        chk("pix", pix, e.pix);
        chk("pix_lat", cyc, e.cyc);
      end
    end
  end

  // AR monitor: check each handshake against the expected address list
  always @(negedge clk) begin
    logic [63:0] a;
    if (resetn && axi.arvalid && axi.arready) begin
      if (aq.size() == 0) begin
        chk("ar_extra", aq.size(), 1);
      end else begin
        a = aq.pop_front();
        chk("araddr", axi.araddr, a);
        chk("arlen", axi.arlen, 8'h1F);
        chk("arsize", axi.arsize, 3'd3);
        chk("arburst", axi.arburst, 2'b01);
      end
    end
  end

  task automatic send_burst(input int bank, input int p,
                            input int err_beat, input int last_beat);
    int t;
    logic [63:0] d;
    t = 0;
    while (axi.rready !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    chk("rready_wait", axi.rready, 1'b1);
    for (int k = 0; k <= last_beat; k++) begin
      d = bw(p, k);
      axi.rdata  = d;
      axi.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      axi.rlast  = (k == last_beat);
      axi.rvalid = 1'b1;
      exp_mem[bank][k] = (k == err_beat) ? 64'd0 : d;
      tick();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
  endtask

  task automatic drain(input int bank, input int first_px, input int n);
    int w;
    int s;
    logic [63:0] word;
    pexp_t e;
    for (int i = first_px; i < first_px + n; i++) begin
      w = i / 4;
      s = i % 4;
      word = exp_mem[bank][w] >> (16 * s);
      e.pix = word[11:0];
      e.cyc = cyc + 1;
      pq.push_back(e);
      pix_req = 1'b1;
      tick();
    end
    pix_req = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    pexp_t e;
    axi.arready = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    aq.push_back(64'h1000);
    aq.push_back(64'h1100);
    aq.push_back(64'h1000);
    aq.push_back(64'h1100);

    @(negedge clk);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_arlen", axi.arlen, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix", pix, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_rerr", rerr, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    base   = 64'h1000;
    top    = 64'h1200;
    enable = 1'b1;

    for (int i = 0; i < 2; i++) begin
      e.pix = 12'h000;
      e.cyc = cyc + 1;
      pq.push_back(e);
      pix_req = 1'b1;
      tick();
    end
    pix_req = 1'b0;
    tick();
    chk("underrun_set", underrun, 1);
    pulse_clr();
    chk("underrun_clr", underrun, 0);

    t = 0;
    while (axi.arvalid !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_arvalid", axi.arvalid, 1);
      chk("hold_araddr", axi.araddr, 64'h1000);
      chk("hold_rready", axi.rready, 0);
      tick();
    end
    axi.arready = 1'b1;
    tick();
    chk("hs_rready", axi.rready, 1);
    chk("hs_arvalid", axi.arvalid, 0);

    send_burst(0, 0, 5, 31);
    chk("rerr_resp", rerr, 1);
    send_burst(1, 1, -1, 31);
    pulse_clr();
    chk("rerr_clr", rerr, 0);

    drain(0, 0, 128);
    send_burst(0, 2, -1, 3);
    chk("rerr_early_last", rerr, 1);

    drain(1, 0, 128);
    drain(0, 0, 24);
    for (int i = 0; i < 5; i++) tick();

`ifdef SELF_TEST_EN
    self_test = 1'b1;
    for (int i = 0; i < 128; i++) begin
      e.pix = (i < 64) ? 12'h000 : 12'hFFF;
      e.cyc = cyc + 1;
      pq.push_back(e);
      pix_req = 1'b1;
      tick();
    end
    pix_req   = 1'b0;
    self_test = 1'b0;
    tick();
    tick();
    chk("st_no_underrun", underrun, 0);
`endif

    chk("pix_queue_empty", pq.size(), 0);
    chk("ar_queue_empty", aq.size(), 0);
    chk("underrun_final", underrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pingpong_fetch.md
Name: vga_pingpong_fetch

Overview:
Parametrised successor of the VGA frame-fetch ping-pong buffer. It runs in a single clock domain and issues AXI4 INCR read bursts over a circular frame region `[base_addr_i, top_addr_i)`. Returned beats fill two alternating banks, and the banks are drained to the VGA controller as fixed-width pixels. It adds full AR/R handshaking, per-bank full/empty tracking, underrun and error reporting, and parametrised width, burst depth and pixel packing.

Parameters:
- `ADDR_WIDTH`, 64, AXI address width.
- `DATA_WIDTH`, 64, AXI read data width. Must be a power of 2 and at least 32.
- `PIX_WIDTH`, 12, pixel bits delivered per request.
- `PIX_SLOT`, 16, bits occupied by one pixel in a data word. `PIX_WIDTH` ≤ `PIX_SLOT`, and `PIX_SLOT` divides `DATA_WIDTH`.
- `BURST_LEN`, 32, beats per burst and words per bank. Power of 2, 2..256.

Ports:
- `clk_a` in 1: single block clock.
- `resetn_a` in 1: asynchronous active-low reset.
- `enable_i` in 1: fetch enable.
- `base_addr_i` in `ADDR_WIDTH`: frame start address. Sampled on the rising edge of `enable_i`.
- `top_addr_i` in `ADDR_WIDTH`: frame end address, exclusive. Sampled on the rising edge of `enable_i`.
- `pix_req_i` in 1: pixel request from the VGA controller.
- `self_test_i` in 1: self-test select. Ignored unless `SELF_TEST_EN` is defined.
- `pix_o` out `PIX_WIDTH`: pixel data.
- `pix_valid_o` out 1: pulses with `pix_o`.
- `underrun_o` out 1: sticky. Set by a request while no bank is readable.
- `rerr_o` out 1: sticky. Set by a non-OKAY `rresp_i`.
- `clr_i` in 1: clears `underrun_o` and `rerr_o`.
- `araddr_o` out `ADDR_WIDTH`; `arlen_o` out 8; `arsize_o` out 3; `arburst_o` out 2; `arvalid_o` out 1; `arready_i` in 1: AXI AR channel.
- `rdata_i` in `DATA_WIDTH`; `rresp_i` in 2; `rlast_i` in 1; `rvalid_i` in 1; `rready_o` out 1: AXI R channel.

Behaviour:
- Reset values: all outputs 0; both banks EMPTY; fill pointer and drain pointer on bank 0; `next_addr` 0.
- Derived constants:
  - `SLOTS = DATA_WIDTH/PIX_SLOT`.
  - `BURST_BYTES = BURST_LEN*DATA_WIDTH/8`.
  - `arlen_o = BURST_LEN-1`.
  - `arsize_o = log2(DATA_WIDTH/8)`.
  - `arburst_o = 2'b01`.
  - These are held constant from reset release onward.
- Enable rising edge: latch base and top addresses and set `next_addr = base`.
- Fetch FSM states: IDLE, ADDR, DATA.
  - IDLE→ADDR when `enable_i` is high and the fill bank is EMPTY. The fill bank becomes FILLING. `araddr_o <= next_addr`, `arvalid_o <= 1`.
  - ADDR: `arvalid_o` and `araddr_o` stay stable until `arready_i`. On handshake: `arvalid_o <= 0`, `rready_o <= 1`, go to DATA. Then `next_addr += BURST_BYTES`; if the sum is ≥ top, wrap to the latched base. Compare at `ADDR_WIDTH+1` bits.
  - DATA: each `rvalid_i && rready_o` beat writes `bank[fill][beat] = rdata_i`, or all zeros if `rresp_i != 0` (which also sets `rerr_o`). `beat` increments.
  - DATA exit: on the beat with `beat == BURST_LEN-1`, or on `rlast_i`, whichever comes first. If `rlast_i` arrives early, set `rerr_o`; unwritten words are stale. Then `rready_o <= 0`, the bank becomes FULL, the fill pointer toggles, and the FSM returns to IDLE.
- `enable_i` low mid-burst: the current burst completes. No new AR is issued. Filled banks remain readable.
- Drain: each `pix_req_i` cycle reads slot `s` of word `w` of the drain bank, if that bank is FULL.
  - `pix_o <= word[s*PIX_SLOT +: PIX_WIDTH]` and `pix_valid_o <= 1` on the next cycle (1-cycle latency).
  - `s` increments. At `s == SLOTS-1`, `w` increments.
  - At the last slot of word `BURST_LEN-1`, the bank becomes EMPTY in the same cycle and the drain pointer toggles.
- Underrun: `pix_req_i` while the drain bank is not FULL gives `pix_o <= 0`, `pix_valid_o <= 1`, `underrun_o <= 1`. Pointers do not advance.
- A bank freed by drain is re-fillable on the next cycle. Fill-complete and drain-complete on different banks in the same cycle are both honoured.
- `clr_i` together with a new error or underrun: the set wins.
- Reset asserted mid-burst: asynchronous return to the reset state. Any outstanding AXI transaction is abandoned; the system resets the interconnect alongside.

Optional Feature:
`SELF_TEST_EN`:
- Defined: while `self_test_i` is high, `pix_o` comes from an 8-entry colour table forming colour bars.
  - Table order: black, white, red, green, blue, yellow, cyan, magenta (12-bit `RGB444`, zero-extended or truncated to `PIX_WIDTH`).
  - The index advances every 64 requests and wraps.
  - Banks are not drained. `underrun_o` is not set. Fetch continues.
- Undefined: `self_test_i` is ignored, and no colour table or bar counter exists.

Decomposition:
- Package `vga_pkg`: the colour constants; the bank state enum `{EMPTY, FILLING, FULL}`; the fetch state enum; AXI encodings `BURST_INCR` and `RESP_OKAY`.
- Sub-module `vga_pp_bank`: one bank with `BURST_LEN×DATA_WIDTH` storage, write port, combinational read port, and state register. Instantiated twice.

Test Plan:
- Defaults, base `0x1000`, top `0x1200`, arready always high → AR addresses `0x1000`, `0x1100`, `0x1000`, with `arlen` `0x1F`, `arsize` 3, `arburst` 1.
- Word `0x0ABC_0DEF_0123_0456` in beat 0, four requests → `pix_o` = `0x456`, `0x123`, `0xDEF`, `0xABC`, each one cycle after its request.
- `arready_i` held low 10 cycles → `arvalid_o`/`araddr_o` stable throughout; `rready_o` stays 0 until the handshake.
- Requests before the first burst completes → `pix_o = 0`, `underrun_o = 1`; `clr_i` then clears it.
- `rresp = 2'b10` on beat 5 → `rerr_o = 1`; the corresponding pixels read 0; fetch continues.
- `SELF_TEST_EN`, `self_test_i = 1`, 128 requests → 64 pixels of `0x000`, then 64 of `0xFFF`; no underrun.
